// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's request/grant/read-return bundle.
// master = requester side, slave = arbiter side.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   logic                    req;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH/8-1:0] wben;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    gnt;
   logic                    rvalid;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (output req, addr, wben, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, addr, wben, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port memory between two requesters.
// Define MEM_ARB_STATS_EN to build the grant/conflict statistics counters.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   mem_port_arbiter_if.slave       p0,
   mem_port_arbiter_if.slave       p1,
   output logic                    mem_en_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH/8-1:0] mem_wben_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_stall_i,
   output logic [31:0]             stat_grants0_o,
   output logic [31:0]             stat_grants1_o,
   output logic [31:0]             stat_conflict_o
);
   localparam int            CW  = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

   logic [1:0]            req;
   logic                  hold, sel, gnt, rd;
   logic                  owner_q, owner_d, last_q, last_d, active_q, active_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [RD_LATENCY-1:0] tv_q, tv_d, tp_q, tp_d;

   always_comb begin
      req  = {p1.req, p0.req};
      hold = active_q & req[owner_q] & ((cnt_q < CAP) | ~req[~owner_q]);
      sel  = hold ? owner_q : (&req) ? ~last_q : req[1];
      gnt  = (|req) & ~mem_stall_i;
      rd   = gnt & ~|(sel ? p1.wben : p0.wben);
      p0.gnt      = gnt & ~sel;
      p1.gnt      = gnt & sel;
      mem_en_o    = gnt;
      mem_addr_o  = gnt ? (sel ? p1.addr : p0.addr) : '0;
      mem_wben_o  = gnt ? (sel ? p1.wben : p0.wben) : '0;
      mem_wdata_o = gnt ? (sel ? p1.wdata : p0.wdata) : '0;
      owner_d  = owner_q;
      last_d   = last_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      if (gnt) begin
         owner_d  = sel;
         last_d   = sel;
         active_d = 1'b1;
         cnt_d    = (sel == owner_q && active_q) ? ((cnt_q == CAP) ? CAP : cnt_q + 1'b1) : '0;
      end else if (~|req && ~mem_stall_i) begin
         active_d = 1'b0;
         cnt_d    = '0;
      end
      // read tags shift every cycle regardless of stall; writes enter as invalid
      tv_d = RD_LATENCY'({tv_q, rd});
      tp_d = RD_LATENCY'({tp_q, sel});
      p0.rvalid = tv_q[RD_LATENCY-1] & ~tp_q[RD_LATENCY-1];
      p1.rvalid = tv_q[RD_LATENCY-1] & tp_q[RD_LATENCY-1];
      p0.rdata  = mem_rdata_i;
      p1.rdata  = mem_rdata_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         active_q <= 1'b0;
         cnt_q    <= '0;
         tv_q     <= '0;
         tp_q     <= '0;
      end else begin
         owner_q  <= owner_d;
         last_q   <= last_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         tv_q     <= tv_d;
         tp_q     <= tp_d;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] g0_q, g0_d, g1_q, g1_d, cf_q, cf_d;

   always_comb begin
      g0_d = g0_q + 32'(p0.gnt);
      g1_d = g1_q + 32'(p1.gnt);
      cf_d = cf_q + 32'(&req);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         g0_q <= '0;
         g1_q <= '0;
         cf_q <= '0;
      end else begin
         g0_q <= g0_d;
         g1_q <= g1_d;
         cf_q <= cf_d;
      end
   end

   assign stat_grants0_o  = g0_q;
   assign stat_grants1_o  = g1_q;
   assign stat_conflict_o = cf_q;
`else
   assign stat_grants0_o  = '0;
   assign stat_grants1_o  = '0;
   assign stat_conflict_o = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized two-requester traffic checked against a burst/round-robin model.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int MB = 4;
   localparam int RL = 3;

   logic clk_i = 1'b0;
   logic reset_n_i;
   always #5 clk_i = ~clk_i;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

   logic          mem_en, mem_stall;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wben;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [31:0]   sg0, sg1, scf;

   logic          rq [2];
   logic [AW-1:0] ad [2];
   logic [7:0]    wb [2];
   logic [DW-1:0] wd [2];
   bit            done [2];

   assign p0_if.req = rq[0];
   assign p0_if.addr = ad[0];
   assign p0_if.wben = wb[0];
   assign p0_if.wdata = wd[0];
   assign p1_if.req = rq[1];
   assign p1_if.addr = ad[1];
   assign p1_if.wben = wb[1];
   assign p1_if.wdata = wd[1];

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .RD_LATENCY(RL)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .p0(p0_if.slave), .p1(p1_if.slave),
      .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_wben_o(mem_wben), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .mem_stall_i(mem_stall),
      .stat_grants0_o(sg0), .stat_grants1_o(sg1), .stat_conflict_o(scf)
   );

   function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [63:0] init_word(int i);
      return {2{32'hA5A50000 | 32'(i)}};
   endfunction

   // memory environment: RL-cycle read pipe, byte-enabled writes
   logic [63:0] mem [16];
   logic [63:0] rdp [RL];
   always @(posedge clk_i) begin
      rdp[0] <= (mem_en && mem_wben == 8'h0) ? mem[mem_addr[6:3]] : 64'h0;
      for (int i = 1; i < RL; i++) rdp[i] <= rdp[i-1];
      if (!reset_n_i) for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      else if (mem_en && mem_wben != 8'h0) mem[mem_addr[6:3]] <= merge(mem[mem_addr[6:3]], mem_wdata, mem_wben);
   end
   assign mem_rdata = rdp[RL-1];

   int n_tests = 0, n_fail = 0;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   int          m_owner, m_run, m_last;
   bit          m_active;
   int          qp [$];
   logic [63:0] qd [$];
   logic [63:0] ref_mem [16];
   int          n_g0, n_g1, n_cf;

   task automatic model_reset();
      m_owner = 0; m_run = 0; m_last = 1; m_active = 0;
      qp = {}; qd = {};
      repeat (RL) begin qp.push_back(-1); qd.push_back(64'h0); end
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      n_g0 = 0; n_g1 = 0; n_cf = 0;
   endtask

   task automatic check_stats();
`ifdef MEM_ARB_STATS_EN
      check("stat_grants0", sg0, 64'(n_g0));
      check("stat_grants1", sg1, 64'(n_g1));
      check("stat_conflict", scf, 64'(n_cf));
`else
      check("stat_grants0", sg0, 64'h0);
      check("stat_grants1", sg1, 64'h0);
      check("stat_conflict", scf, 64'h0);
`endif
   endtask

   task automatic step(int p0pct, int p1pct, int pst, int prd);
      int s, ep;
      bit g, any;
      logic [63:0] ed;
      @(negedge clk_i);
      for (int k = 0; k < 2; k++) begin
         if (done[k]) begin rq[k] = 1'b0; done[k] = 1'b0; end
         if (!rq[k] && $urandom_range(0, 99) < ((k == 0) ? p0pct : p1pct)) begin
            rq[k] = 1'b1;
            ad[k] = 32'h100 | (32'($urandom_range(0, 15)) << 3);
            wb[k] = ($urandom_range(0, 99) < prd) ? 8'h0 : 8'($urandom_range(1, 255));
            wd[k] = {$urandom, $urandom};
         end
      end
      mem_stall = $urandom_range(0, 99) < pst;
      #1;
      any = rq[0] || rq[1];
      // a burst holder keeps the port until MB grants, or longer if nobody else waits
      if (m_active && rq[m_owner] && (m_run < MB || !rq[1-m_owner])) s = m_owner;
      else if (rq[0] && rq[1]) s = 1 - m_last;
      else s = rq[1] ? 1 : 0;
      g = any && !mem_stall;
      check("gnt0", p0_if.gnt, g && s == 0);
      check("gnt1", p1_if.gnt, g && s == 1);
      check("mem_en", mem_en, g);
      check("mem_addr", mem_addr, g ? ad[s] : 0);
      check("mem_wben", mem_wben, g ? wb[s] : 0);
      check("mem_wdata", mem_wdata, g ? wd[s] : 0);
      ep = qp.pop_front();
      ed = qd.pop_front();
      check("rvalid0", p0_if.rvalid, ep == 0);
      check("rvalid1", p1_if.rvalid, ep == 1);
      if (ep >= 0) check("rdata", (ep == 1) ? p1_if.rdata : p0_if.rdata, ed);
      if (g && wb[s] == 8'h0) begin
         qp.push_back(s);
         qd.push_back(ref_mem[ad[s][6:3]]);
      end else begin
         qp.push_back(-1);
         qd.push_back(64'h0);
      end
      if (g && wb[s] != 8'h0) ref_mem[ad[s][6:3]] = merge(ref_mem[ad[s][6:3]], wd[s], wb[s]);
      if (g && s == 0) n_g0++;
      if (g && s == 1) n_g1++;
      if (rq[0] && rq[1]) n_cf++;
      if (g) begin
         m_run = (m_active && s == m_owner) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
         m_owner = s; m_last = s; m_active = 1; done[s] = 1'b1;
      end else if (!any && !mem_stall) begin
         m_active = 0; m_run = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_n_i = 1'b0;
      rq[0] = 1'b0; rq[1] = 1'b0; done[0] = 1'b0; done[1] = 1'b0;
      mem_stall = 1'b0;
      model_reset();
      #1;
      check("rst_gnt0", p0_if.gnt, 0);
      check("rst_gnt1", p1_if.gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rvalid0", p0_if.rvalid, 0);
      check("rst_rvalid1", p1_if.rvalid, 0);
      check_stats();
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   initial begin
      reset_n_i = 1'b0;
      mem_stall = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rq[k] = 1'b0; ad[k] = '0; wb[k] = '0; wd[k] = '0; done[k] = 1'b0;
      end
      do_reset();
      step(100, 0, 0, 100);
      repeat (5) step(0, 0, 0, 0);
      repeat (24) step(100, 100, 0, 100);
      check_stats();
      repeat (4) step(0, 0, 0, 0);
      repeat (2) step(0, 100, 0, 50);
      repeat (8) step(100, 100, 0, 50);
      repeat (4) step(0, 0, 0, 0);
      repeat (5) step(100, 100, 100, 50);
      repeat (12) step(100, 100, 0, 50);
      repeat (3000) step(40, 40, 15, 50);
      repeat (2000) step(90, 90, 20, 50);
      check_stats();
      repeat (4) step(100, 100, 0, 100);
      do_reset();
      repeat (6) step(0, 0, 0, 0);
      repeat (6) step(100, 100, 0, 100);
      check_stats();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
